// File: rtl/cam_pipe_if.sv
// cam_pipe_if: update, search-request and result bundle for cam_pipe
// master drives updates, search requests and result_ready_i; slave is the CAM.
interface cam_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  write_i;
    logic [ADDR_WIDTH-1:0] write_index_i;
    logic [DATA_WIDTH-1:0] write_data_i;
    logic                  inval_i;
    logic [ADDR_WIDTH-1:0] inval_index_i;
    logic                  flush_i;
    logic                  search_valid_i;
    logic                  search_ready_o;
    logic [DATA_WIDTH-1:0] search_data_i;
    logic [DATA_WIDTH-1:0] search_mask_i;
    logic [ADDR_WIDTH-1:0] start_i;
    logic [ADDR_WIDTH-1:0] end_i;
    logic                  result_valid_o;
    logic                  result_ready_i;
    logic                  result_hit_o;
    logic [ADDR_WIDTH-1:0] result_index_o;
    logic                  result_multi_o;

    modport master (
        output write_i, write_index_i, write_data_i, inval_i, inval_index_i, flush_i,
        output search_valid_i, search_data_i, search_mask_i, start_i, end_i, result_ready_i,
        input  search_ready_o, result_valid_o, result_hit_o, result_index_o, result_multi_o
    );

    modport slave (
        input  write_i, write_index_i, write_data_i, inval_i, inval_index_i, flush_i,
        input  search_valid_i, search_data_i, search_mask_i, start_i, end_i, result_ready_i,
        output search_ready_o, result_valid_o, result_hit_o, result_index_o, result_multi_o
    );
endinterface

// File: rtl/cam_pipe.sv
// cam_pipe: ternary CAM with valid bits and a 2-stage windowed search pipeline
// clk, rst (async active-low); bus carries writes/inval/flush, the search
// request (valid/ready, key, mask, start/end window) and the result
// (valid/ready, hit, first index in window order, multi).
module cam_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int CAM_DEPTH  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic     clk,
    input logic     rst,
    cam_pipe_if.slave bus
);
    logic [DATA_WIDTH-1:0] mem [CAM_DEPTH];
    logic [CAM_DEPTH-1:0]  valid, match, s1_match, win, hi;
    logic [ADDR_WIDTH-1:0] s1_start, s1_end, first_idx, r_index;
    logic                  s1_valid, s2_valid, adv1, adv2, w_ok, i_ok, any_hi;
    logic                  r_hit, r_multi;

    assign adv2 = !s2_valid || bus.result_ready_i;
    assign adv1 = !s1_valid || adv2;
    assign w_ok = 32'(bus.write_index_i) < CAM_DEPTH;
    assign i_ok = 32'(bus.inval_index_i) < CAM_DEPTH;

    // Match against pre-edge contents: same-edge updates never leak into the search.
    always_comb begin
        match = '0;
        for (int e = 0; e < CAM_DEPTH; e++)
            match[e] = valid[e] && &((mem[e] ~^ bus.search_data_i) | ~bus.search_mask_i);
    end

    // hi holds window hits at or above start; in wrap mode those outrank 0..end,
    // and in linear mode every window hit is already in hi.
    always_comb begin
        win = '0;
        hi  = '0;
        for (int e = 0; e < CAM_DEPTH; e++) begin
            win[e] = s1_match[e] && ((s1_start <= s1_end)
                   ? (ADDR_WIDTH'(e) >= s1_start && ADDR_WIDTH'(e) <= s1_end)
                   : (ADDR_WIDTH'(e) >= s1_start || ADDR_WIDTH'(e) <= s1_end));
            hi[e]  = win[e] && ADDR_WIDTH'(e) >= s1_start;
        end
    end

    assign any_hi = |hi;

    always_comb begin
        first_idx = '0;
        for (int e = CAM_DEPTH - 1; e >= 0; e--)
            if (any_hi ? hi[e] : win[e]) first_idx = ADDR_WIDTH'(e);
    end

    always_ff @(posedge clk)
        if (bus.write_i && w_ok) mem[bus.write_index_i] <= bus.write_data_i;

    // Later statements win: inval overrides write, flush overrides both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (bus.flush_i) begin
            valid <= '0;
        end else begin
            if (bus.write_i && w_ok) valid[bus.write_index_i] <= 1'b1;
            if (bus.inval_i && i_ok) valid[bus.inval_index_i] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_match <= '0;
            s1_start <= '0;
            s1_end   <= '0;
            s2_valid <= 1'b0;
            r_hit    <= 1'b0;
            r_index  <= '0;
            r_multi  <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= bus.search_valid_i;
                if (bus.search_valid_i) begin
                    s1_match <= match;
                    s1_start <= bus.start_i;
                    s1_end   <= bus.end_i;
                end
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    r_hit   <= |win;
                    r_index <= first_idx;
                    r_multi <= |(win & (win - CAM_DEPTH'(1)));
                end
            end
        end
    end

    assign bus.search_ready_o = adv1;
    assign bus.result_valid_o = s2_valid;
    assign bus.result_hit_o   = r_hit;
    assign bus.result_index_o = r_index;
    assign bus.result_multi_o = r_multi;
endmodule

// File: tb/tb_cam_pipe.sv
// tb_cam_pipe: directed self-checking bench for cam_pipe
module tb_cam_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cam_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    cam_pipe #(.DATA_WIDTH(32), .CAM_DEPTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] i, input logic [31:0] d);
        bus.write_i = 1'b1;
        bus.write_index_i = i;
        bus.write_data_i = d;
        tick;
        bus.write_i = 1'b0;
    endtask

    task automatic srch(input string tag, input logic [31:0] d, input logic [31:0] m,
                        input logic [4:0] s, input logic [4:0] e,
                        input logic hit, input logic [4:0] idx, input logic multi);
        int n;
        bus.search_data_i = d;
        bus.search_mask_i = m;
        bus.start_i = s;
        bus.end_i = e;
        bus.search_valid_i = 1'b1;
        n = 0;
        while (!bus.search_ready_o && n < 10) begin
            tick;
            n++;
        end
        chk({tag, "_acc"}, 32'(bus.search_ready_o), 1);
        tick;
        bus.search_valid_i = 1'b0;
        bus.write_i = 1'b0;
        bus.inval_i = 1'b0;
        bus.flush_i = 1'b0;
        n = 0;
        while (!bus.result_valid_o && n < 5) begin
            tick;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 1);
        chk({tag, "_hit"}, 32'(bus.result_hit_o), 32'(hit));
        chk({tag, "_idx"}, 32'(bus.result_index_o), 32'(idx));
        chk({tag, "_multi"}, 32'(bus.result_multi_o), 32'(multi));
        tick;
    endtask

    logic [31:0] keys [4] = '{32'hA5A5_0001, 32'hA5A5_0002, 32'h55, 32'h66};
    logic [4:0]  exp_idx [4] = '{5'd3, 5'd7, 5'd12, 5'd20};

    initial begin
        int sent, got, first_c, last_c;
        bus.write_i = 0; bus.write_index_i = 0; bus.write_data_i = 0;
        bus.inval_i = 0; bus.inval_index_i = 0; bus.flush_i = 0;
        bus.search_valid_i = 0; bus.search_data_i = 0; bus.search_mask_i = 0;
        bus.start_i = 0; bus.end_i = 0; bus.result_ready_i = 1;
        #3;
        chk("rst_valid", 32'(bus.result_valid_o), 0);
        chk("rst_hit", 32'(bus.result_hit_o), 0);
        chk("rst_idx", 32'(bus.result_index_o), 0);
        chk("rst_multi", 32'(bus.result_multi_o), 0);
        #4 rst = 1'b1;
        tick;
        chk("rst_ready", 32'(bus.search_ready_o), 1);

        wr(5'd3, 32'hA5A5_0001);
        wr(5'd7, 32'hA5A5_0002);
        srch("exact", 32'hA5A5_0001, 32'hFFFF_FFFF, 0, 31, 1, 3, 0);
        srch("tern", 32'hA5A5_0000, 32'hFFFF_FFFC, 0, 31, 1, 3, 1);
        srch("wrap54", 32'hA5A5_0000, 32'hFFFF_FFFC, 5, 4, 1, 7, 1);
        srch("wrap84", 32'hA5A5_0000, 32'hFFFF_FFFC, 8, 4, 1, 3, 0);
        srch("win46", 32'hA5A5_0000, 32'hFFFF_FFFC, 4, 6, 0, 0, 0);
        srch("single7", 32'hA5A5_0000, 32'hFFFF_FFFC, 7, 7, 1, 7, 0);
        srch("mask0", 32'h0, 32'h0, 0, 31, 1, 3, 1);

        bus.write_i = 1; bus.write_index_i = 9; bus.write_data_i = 32'h11;
        srch("hazard", 32'h11, 32'hFFFF_FFFF, 0, 31, 0, 0, 0);
        srch("after", 32'h11, 32'hFFFF_FFFF, 0, 31, 1, 9, 0);
        bus.write_i = 1; bus.write_index_i = 9; bus.write_data_i = 32'h11;
        bus.inval_i = 1; bus.inval_index_i = 9;
        tick;
        bus.write_i = 0; bus.inval_i = 0;
        srch("wr_inval", 32'h11, 32'hFFFF_FFFF, 0, 31, 0, 0, 0);

        wr(5'd12, 32'h55);
        wr(5'd20, 32'h66);
        bus.result_ready_i = 0;
        bus.search_mask_i = 32'hFFFF_FFFF;
        bus.start_i = 0;
        bus.end_i = 31;
        sent = 0;
        for (int c = 0; c < 4; c++) begin
            bus.search_data_i = keys[sent];
            bus.search_valid_i = 1;
            if (bus.search_ready_o) sent++;
            tick;
            if (c >= 1) begin
                chk("bp_valid", 32'(bus.result_valid_o), 1);
                chk("bp_hold_idx", 32'(bus.result_index_o), 3);
            end
        end
        chk("bp_accepted", 32'(sent), 2);
        chk("bp_ready_low", 32'(bus.search_ready_o), 0);
        bus.result_ready_i = 1;
        #1;
        chk("bp_ready_comb", 32'(bus.search_ready_o), 1);
        got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 12; c++) begin
            bus.search_valid_i = (sent < 4);
            if (sent < 4) bus.search_data_i = keys[sent];
            if (bus.result_valid_o && got < 4) begin
                chk("bp_order", 32'(bus.result_index_o), 32'(exp_idx[got]));
                got++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (bus.search_valid_i && bus.search_ready_o) begin
                tick;
                sent++;
            end else begin
                tick;
            end
        end
        bus.search_valid_i = 0;
        chk("bp_count", 32'(got), 4);
        chk("bp_rate", 32'(last_c - first_c), 3);

        bus.result_ready_i = 0;
        bus.search_data_i = 32'hA5A5_0001;
        bus.search_valid_i = 1;
        tick;
        tick;
        bus.search_valid_i = 0;
        chk("rm_pre", 32'(bus.result_valid_o), 1);
        #2 rst = 1'b0;
        #1;
        chk("rm_valid", 32'(bus.result_valid_o), 0);
        @(posedge clk);
        #3 rst = 1'b1;
        bus.result_ready_i = 1;
        tick;
        chk("rm_idle", 32'(bus.result_valid_o), 0);
        srch("rm_lost", 32'hA5A5_0001, 32'hFFFF_FFFF, 0, 31, 0, 0, 0);
        wr(5'd5, 32'h77);
        srch("rm_new", 32'h77, 32'hFFFF_FFFF, 0, 31, 1, 5, 0);
        bus.flush_i = 1;
        bus.write_i = 1; bus.write_index_i = 6; bus.write_data_i = 32'h88;
        tick;
        bus.flush_i = 0; bus.write_i = 0;
        srch("flush", 32'h0, 32'h0, 0, 31, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cam_pipe.md
Name: cam_pipe

Overview:
- Next-generation content-addressable memory for the FIX parser tag/field lookup path.
- Adds per-entry valid bits, a ternary search mask, invalidate/flush, and wrap-around search windows.
- Search is a 2-stage pipeline with valid/ready handshakes on both the request and result sides, so it can sit between streaming parser stages with backpressure.

Parameters:
DATA_WIDTH, 32, width of a stored key and of the search key
CAM_DEPTH, 32, number of entries
ADDR_WIDTH, 5, index width; must satisfy 2**ADDR_WIDTH >= CAM_DEPTH

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous active-low reset
write_i  input  1  write strobe; always accepted
write_index_i  input  ADDR_WIDTH  entry to write
write_data_i  input  DATA_WIDTH  key to store
inval_i  input  1  invalidate strobe for the entry at inval_index_i
inval_index_i  input  ADDR_WIDTH  entry to invalidate
flush_i  input  1  clear all valid bits
search_valid_i  input  1  search request valid
search_ready_o  output  1  search request accepted when valid and ready are both high
search_data_i  input  DATA_WIDTH  search key
search_mask_i  input  DATA_WIDTH  1 = bit compared, 0 = don't-care
start_i  input  ADDR_WIDTH  first index of the search window
end_i  input  ADDR_WIDTH  last index of the search window
result_valid_o  output  1  result available
result_ready_i  input  1  result consumed when valid and ready are both high
result_hit_o  output  1  at least one valid match inside the window
result_index_o  output  ADDR_WIDTH  first matching index in window order
result_multi_o  output  1  two or more matches inside the window

Behaviour:
- Reset (rst low, asynchronous):
  - All valid bits clear.
  - Stage-1 and stage-2 valid flags clear.
  - result_valid_o, result_hit_o and result_multi_o are 0; result_index_o is 0.
  - search_ready_o is 1 once rst is released.
  - Data storage is not reset.
  - A search in flight at reset is discarded with no result.
- Write:
  - write_i sets the entry data and its valid bit at the clock edge.
  - write_index_i >= CAM_DEPTH is ignored.
- Invalidate and flush:
  - inval_i clears the valid bit of the addressed entry; out-of-range index is ignored.
  - flush_i clears all valid bits.
- Update priority on the same edge: flush > inval > write.
  - write plus inval to the same index leaves the entry invalid.
  - write plus flush leaves every entry invalid.
- Match rule:
  - Entry e matches iff its valid bit is set and ((stored[e] XNOR search_data_i) OR ~search_mask_i) is all ones.
  - search_mask_i = 0 matches every valid entry.
- Stage 1:
  - On acceptance, the match vector is computed against array contents before that edge's write/inval/flush.
  - That vector is registered with start_i and end_i.
  - Later updates never affect an accepted search.
- Stage 2: a window filter and rotating priority encoder register hit, index and multi.
- Window:
  - If start_i <= end_i, the window is start..end inclusive, with priority to the lowest index.
  - If start_i > end_i, the window wraps: start..CAM_DEPTH-1, then 0..end. Priority follows that order, so the index nearest to start going upward wins.
  - Indices >= CAM_DEPTH are never in the window.
  - start_i = end_i is a single-entry window.
- When result_hit_o = 0:
  - result_index_o = 0.
  - result_multi_o = 0.
- Handshake:
  - adv2 = !s2_valid | result_ready_i.
  - adv1 = !s1_valid | adv2.
  - search_ready_o = adv1 (combinational from result_ready_i).
  - Latency: a search accepted at edge N gives result_valid_o high after edge N+1, with no backpressure.
  - Back-to-back searches sustain one per cycle.
  - The result outputs hold stable while result_valid_o is high and result_ready_i is low.
  - At most 2 searches are in flight.
- Outputs are registered except search_ready_o.

Test Plan:
- Reset, then write 0xA5A5_0001 at index 3 and 0xA5A5_0002 at index 7. Search 0xA5A5_0001, mask all-ones, window 0..31, result_ready_i=1 -> result after 2 cycles with hit=1, index=3, multi=0.
- Same contents, search 0xA5A5_0000 with mask 0xFFFF_FFFC, window 0..31 -> hit=1, index=3, multi=1.
- Wrap-around: same contents, start=5, end=4, mask 0xFFFF_FFFC -> index=7. Then start=8, end=4 -> index=3. Then start=4, end=6 -> hit=0, index=0.
- Hazard and priority:
  - Search key 0x11 at index 9 while writing 0x11 to index 9 in the same cycle -> hit=0.
  - The next search -> hit=1, index=9.
  - Simultaneous write and inval to index 9, then search -> hit=0.
- Backpressure: issue 4 consecutive searches with result_ready_i=0 -> search_ready_o drops after 2 are accepted and result_valid_o holds the first result stable. Raise result_ready_i -> all 4 results emerge in order, one per cycle.
- Reset mid-operation: assert rst low with 2 searches in flight -> result_valid_o=0 immediately; after release, a search for a previously written key gives hit=0. flush_i then search -> hit=0.
